io_input_port: RTL and testbench
================================

// Module: io_input_port
// PURPOSE
//   FPGA-side producer for the processor's 16-bit FPGAIn input path.
//   - Samples board switches and an ENTER push-button; debounces the button.
//   - Latches one switch word per press and presents it on FPGAIn.
//   - Uses a ready/acknowledge handshake so the CPU's input instruction consumes each word exactly once.
//   - Sits between the board pins and the integration top level.
// PARAMETERS
//   WIDTH            16   data word width (matches the CPU datapath)
//   SYNC_STAGES      2    synchronizer flops on SwitchIn and EnterBtn (>=2)
//   DEBOUNCE_CYCLES  4    consecutive stable samples needed for press/release (>=1; board build uses 500000)
// PORTS
//   CLK        in   1      system clock; all logic on the rising edge
//   reset      in   1      synchronous, active-high reset
//   SwitchIn   in   WIDTH  raw asynchronous board switches
//   EnterBtn   in   1      raw asynchronous ENTER button, 1 = pressed
//   RdAck      in   1      one-cycle pulse from the CPU control unit when an input instruction reads FPGAIn
//   FPGAIn     out  WIDTH  latched word to the CPU; holds until the next capture
//   InReady    out  1      1 = FPGAIn holds an unconsumed word
//   Overrun    out  1      sticky: a word was captured while the previous word was still unconsumed
// BEHAVIOUR
//   Reset (reset=1 at a CLK edge): FPGAIn=0, InReady=0, Overrun=0, sync flops=0, FSM=IDLE, counter=0.
//     Reset in mid-press also discards that press.
//   Sync: btn_s and sw_s are the last of SYNC_STAGES flops. A level change on a pin reaches btn_s/sw_s after SYNC_STAGES edges.
//   Debounce FSM (counter cnt, width $clog2(DEBOUNCE_CYCLES+1)):
//     IDLE:         btn_s=1 -> PRESS_WAIT, cnt=1. Else stay, cnt=0.
//     PRESS_WAIT:   btn_s=0 -> IDLE, cnt=0 (bounce rejected).
//                   btn_s=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD, cnt=0, assert press pulse (capture).
//                   Otherwise cnt++.
//     HELD:         btn_s=0 -> RELEASE_WAIT, cnt=1. Else stay; no further captures however long the button is held.
//     RELEASE_WAIT: btn_s=1 -> HELD, cnt=0.
//                   btn_s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, cnt=0. Otherwise cnt++.
//     DEBOUNCE_CYCLES=1: IDLE goes directly to HELD with a capture.
//   Latency: EnterBtn rising and held stable -> FPGAIn/InReady update at edge SYNC_STAGES+DEBOUNCE_CYCLES after the pin change.
//     That is the 6th edge with the defaults.
//   Capture (on the press-pulse edge): FPGAIn <= sw_s; InReady <= 1.
//     Overrun <= 1 if InReady was 1 and RdAck=0 that cycle.
//   RdAck:
//     - With InReady=1 and no capture: InReady <= 0, Overrun <= 0. FPGAIn is unchanged.
//     - With InReady=0: ignored; no state change.
//   Simultaneous capture + RdAck: the old word counts as consumed. Result: FPGAIn=new word, InReady stays 1, Overrun <= 0.
//   Overrun stays set until RdAck or reset. The overwritten word is lost; the newest word always wins.
//   All outputs are registered; there is no combinational path from any input to any output.
// STRUCTURE
//   Shared package io_pkg:
//     - FSM state constants IDLE=2'd0, PRESS_WAIT=2'd1, HELD=2'd2, RELEASE_WAIT=2'd3
//     - IO_WIDTH=16, shared with the CPU top level
//   Sub-module io_sync_debounce (CLK, reset, raw, clean, press_pulse):
//     - synchronizer, debounce counter and FSM
//     - press_pulse is high for one cycle on the HELD entry edge
//   io_input_port instantiates io_sync_debounce for EnterBtn. It also holds:
//     - the WIDTH-wide switch synchronizer
//     - the data register
//     - the InReady/Overrun handshake logic
// TESTING  (CLK period 30 ns, defaults, reset held for 4 edges first)
//   1. After reset, with SwitchIn=16'hBEEF and EnterBtn=0 -> FPGAIn=0, InReady=0, Overrun=0 for 20 cycles.
//   2. SwitchIn=16'h0010, EnterBtn held high 10 cycles -> FPGAIn=16'h0010 and InReady=1 exactly at edge 6.
//      Exactly one capture occurs. A RdAck pulse then clears InReady the next edge; FPGAIn stays 16'h0010.
//   3. Bounce: EnterBtn pattern 1,1,0,1,0 (one cycle each), then low -> no capture; InReady=0 and FPGAIn unchanged.
//   4. Two clean presses (16'h000A, then 16'h0002) with no RdAck -> FPGAIn=16'h0002, InReady=1, Overrun=1.
//      A following RdAck clears InReady and Overrun together.
//   5. RdAck asserted on the same edge as the capture of 16'h1234 while InReady=1 -> FPGAIn=16'h1234, InReady=1, Overrun=0.
//   6. reset asserted during PRESS_WAIT, then released with the button still high -> outputs 0.
//      A new full debounce is required: capture occurs 6 edges after reset falls.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the FPGA input path: word width and debounce FSM encoding.
package io_pkg;

    localparam int IO_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_e;

endpackage

// File: rtl/io_sync_debounce.sv
// Synchronizes a raw push-button and debounces it; emits a one-cycle press_pulse
// in the cycle whose closing edge enters HELD.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | button released and stable
// PRESS_WAIT   | button seen high, counting stable high samples
// HELD         | press accepted (capture fired on entry), waiting for release
// RELEASE_WAIT | button seen low, counting stable low samples
module io_sync_debounce
    import io_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic CLK,
    input  logic reset,
    input  logic raw,
    output logic clean,
    output logic press_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    db_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   btn_s;

    assign btn_s = sync_q[SYNC_STAGES-1];
    assign clean = (state_q == HELD) || (state_q == RELEASE_WAIT);

    always_ff @(posedge CLK) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], raw};
        state_d     = state_q;
        cnt_d       = cnt_q;
        press_pulse = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (btn_s) begin
                    // A single-sample debounce accepts the press immediately.
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d     = HELD;
                        press_pulse = 1'b1;
                    end else begin
                        state_d = PRESS_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = HELD;
                    cnt_d       = '0;
                    press_pulse = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                cnt_d = '0;
                if (!btn_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/io_input_port.sv
// FPGA-side producer for the CPU FPGAIn path: latches one switch word per debounced
// ENTER press and hands it over with a ready/acknowledge handshake.
module io_input_port
    import io_pkg::*;
#(
    parameter int WIDTH           = IO_WIDTH,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [WIDTH-1:0] SwitchIn,
    input  logic             EnterBtn,
    input  logic             RdAck,
    output logic [WIDTH-1:0] FPGAIn,
    output logic             InReady,
    output logic             Overrun
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sw_sync_q, sw_sync_d;
    logic [WIDTH-1:0]                  data_q, data_d;
    logic                              ready_q, ready_d;
    logic                              ovr_q, ovr_d;
    logic [WIDTH-1:0]                  sw_s;
    logic                              press_pulse;
    logic                              btn_clean_unused;

    io_sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_enter_db (
        .CLK         (CLK),
        .reset       (reset),
        .raw         (EnterBtn),
        .clean       (btn_clean_unused),
        .press_pulse (press_pulse)
    );

    assign sw_s = sw_sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK) begin
        if (reset) begin
            sw_sync_q <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sw_sync_q <= sw_sync_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        sw_sync_d = {sw_sync_q[SYNC_STAGES-2:0], SwitchIn};
        data_d    = data_q;
        ready_d   = ready_q;
        ovr_d     = ovr_q;
        if (press_pulse) begin
            // Newest word always wins; an ack in the same cycle consumes the old one.
            data_d  = sw_s;
            ready_d = 1'b1;
            if (RdAck) begin
                ovr_d = 1'b0;
            end else if (ready_q) begin
                ovr_d = 1'b1;
            end
        end else if (RdAck && ready_q) begin
            ready_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    assign FPGAIn  = data_q;
    assign InReady = ready_q;
    assign Overrun = ovr_q;

endmodule

// File: tb/tb_io_input_port.sv
// Directed testbench for io_input_port with default parameters and a 30 ns clock.
module tb_io_input_port;

    logic        CLK;
    logic        reset;
    logic [15:0] SwitchIn;
    logic        EnterBtn;
    logic        RdAck;
    logic [15:0] FPGAIn;
    logic        InReady;
    logic        Overrun;

    int n_checks = 0;
    int n_fail   = 0;

    io_input_port dut (
        .CLK      (CLK),
        .reset    (reset),
        .SwitchIn (SwitchIn),
        .EnterBtn (EnterBtn),
        .RdAck    (RdAck),
        .FPGAIn   (FPGAIn),
        .InReady  (InReady),
        .Overrun  (Overrun)
    );

    initial CLK = 1'b0;
    always #15 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic press_word(input logic [15:0] w);
        SwitchIn = w;
        EnterBtn = 1'b1;
        repeat (10) tick();
        EnterBtn = 1'b0;
        repeat (10) tick();
    endtask

    task automatic ack_pulse();
        RdAck = 1'b1;
        tick();
        RdAck = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        SwitchIn = 16'hBEEF;
        EnterBtn = 1'b0;
        RdAck    = 1'b0;
        repeat (4) tick();
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            n_checks++;
            if (FPGAIn !== 16'h0000 || InReady !== 1'b0 || Overrun !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: FPGAIn=%h InReady=%b Overrun=%b, want 0000/0/0",
                         k, FPGAIn, InReady, Overrun);
            end
        end
    endtask

    task automatic test_single_capture();
        logic [15:0] exp_data;
        logic        exp_rdy;
        SwitchIn = 16'h0010;
        EnterBtn = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_data = (k >= 6) ? 16'h0010 : 16'h0000;
            exp_rdy  = (k >= 6);
            n_checks++;
            if (FPGAIn !== exp_data || InReady !== exp_rdy || Overrun !== 1'b0) begin
                n_fail++;
                $display("FAIL capture_latency edge %0d: FPGAIn=%h InReady=%b Overrun=%b, want %h/%b/0",
                         k, FPGAIn, InReady, Overrun, exp_data, exp_rdy);
            end
        end
        EnterBtn = 1'b0;
        repeat (10) tick();
        n_checks++;
        if (InReady !== 1'b1 || Overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL single_capture: InReady=%b Overrun=%b, want 1/0", InReady, Overrun);
        end
        ack_pulse();
        n_checks++;
        if (InReady !== 1'b0 || FPGAIn !== 16'h0010) begin
            n_fail++;
            $display("FAIL ack_clear: InReady=%b FPGAIn=%h, want 0/0010", InReady, FPGAIn);
        end
        repeat (3) tick();
        ack_pulse();
        n_checks++;
        if (InReady !== 1'b0 || Overrun !== 1'b0 || FPGAIn !== 16'h0010) begin
            n_fail++;
            $display("FAIL ack_when_empty: InReady=%b Overrun=%b FPGAIn=%h, want 0/0/0010",
                     InReady, Overrun, FPGAIn);
        end
    endtask

    task automatic test_bounce();
        logic [4:0] pat;
        pat      = 5'b11010;
        SwitchIn = 16'hFFFF;
        for (int i = 4; i >= 0; i--) begin
            EnterBtn = pat[i];
            tick();
        end
        EnterBtn = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            n_checks++;
            if (InReady !== 1'b0 || FPGAIn !== 16'h0010 || Overrun !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce_reject cycle %0d: FPGAIn=%h InReady=%b Overrun=%b, want 0010/0/0",
                         k, FPGAIn, InReady, Overrun);
            end
        end
    endtask

    task automatic test_overrun();
        press_word(16'h000A);
        n_checks++;
        if (FPGAIn !== 16'h000A || InReady !== 1'b1 || Overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL first_press: FPGAIn=%h InReady=%b Overrun=%b, want 000A/1/0",
                     FPGAIn, InReady, Overrun);
        end
        press_word(16'h0002);
        n_checks++;
        if (FPGAIn !== 16'h0002 || InReady !== 1'b1 || Overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: FPGAIn=%h InReady=%b Overrun=%b, want 0002/1/1",
                     FPGAIn, InReady, Overrun);
        end
        repeat (5) tick();
        n_checks++;
        if (Overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_sticky: Overrun=%b, want 1", Overrun);
        end
        ack_pulse();
        n_checks++;
        if (FPGAIn !== 16'h0002 || InReady !== 1'b0 || Overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_ack: FPGAIn=%h InReady=%b Overrun=%b, want 0002/0/0",
                     FPGAIn, InReady, Overrun);
        end
    endtask

    task automatic test_back_to_back();
        press_word(16'h5555);
        n_checks++;
        if (FPGAIn !== 16'h5555 || InReady !== 1'b1 || Overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: FPGAIn=%h InReady=%b Overrun=%b, want 5555/1/0",
                     FPGAIn, InReady, Overrun);
        end
        SwitchIn = 16'h1234;
        EnterBtn = 1'b1;
        repeat (5) tick();
        n_checks++;
        if (FPGAIn !== 16'h5555 || InReady !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_pre_edge: FPGAIn=%h InReady=%b, want 5555/1", FPGAIn, InReady);
        end
        RdAck = 1'b1;
        tick();
        RdAck = 1'b0;
        n_checks++;
        if (FPGAIn !== 16'h1234 || InReady !== 1'b1 || Overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL capture_with_ack: FPGAIn=%h InReady=%b Overrun=%b, want 1234/1/0",
                     FPGAIn, InReady, Overrun);
        end
        EnterBtn = 1'b0;
        repeat (10) tick();
        ack_pulse();
        n_checks++;
        if (InReady !== 1'b0 || Overrun !== 1'b0 || FPGAIn !== 16'h1234) begin
            n_fail++;
            $display("FAIL b2b_final_ack: FPGAIn=%h InReady=%b Overrun=%b, want 1234/0/0",
                     FPGAIn, InReady, Overrun);
        end
    endtask

    task automatic test_reset_mid_press();
        logic [15:0] exp_data;
        logic        exp_rdy;
        SwitchIn = 16'h00C3;
        EnterBtn = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (FPGAIn !== 16'h0000 || InReady !== 1'b0 || Overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_press: FPGAIn=%h InReady=%b Overrun=%b, want 0000/0/0",
                     FPGAIn, InReady, Overrun);
        end
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_data = (k >= 6) ? 16'h00C3 : 16'h0000;
            exp_rdy  = (k >= 6);
            n_checks++;
            if (FPGAIn !== exp_data || InReady !== exp_rdy || Overrun !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_capture edge %0d: FPGAIn=%h InReady=%b Overrun=%b, want %h/%b/0",
                         k, FPGAIn, InReady, Overrun, exp_data, exp_rdy);
            end
        end
        EnterBtn = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        reset    = 1'b1;
        SwitchIn = 16'hBEEF;
        EnterBtn = 1'b0;
        RdAck    = 1'b0;
        test_reset();
        test_single_capture();
        test_bounce();
        test_overrun();
        test_back_to_back();
        test_reset_mid_press();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
